// File: rtl/wb_stage.sv
// Writeback stage: selects register-file write data (ALU, load, PC+4), extracts
// sub-word loads, stalls on slow IO reads with a timeout, and counts retired writes.
module wb_stage #(
  parameter int          DWIDTH      = 32,
  parameter int          RAW         = 5,
  parameter int          IO_TIMEOUT  = 16,
  parameter logic [3:0]  DMEM_REGION = 4'b0001,
  parameter logic [3:0]  BIOS_REGION = 4'b0100,
  parameter logic [3:0]  IO_REGION   = 4'b1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [RAW-1:0]    rd_i,
  input  logic              rd_we_i,
  input  logic [1:0]        wb_sel_i,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] alu_result_i,
  input  logic [DWIDTH-1:0] pc_plus4_i,
  input  logic [DWIDTH-1:0] dmem_dout_i,
  input  logic [DWIDTH-1:0] bios_dout_i,
  input  logic [DWIDTH-1:0] io_dout_i,
  input  logic              io_valid_i,
  output logic              stall_o,
  output logic [RAW-1:0]    rd_o,
  output logic              rd_we_o,
  output logic [DWIDTH-1:0] wd_o,
  output logic              misalign_o,
  output logic              err_o,
  output logic [31:0]       wb_count_o,
  output logic              state_o
);

  // Handshake: there is no ready input; upstream must hold every input stable
  // for as long as stall_o is high, and an instruction is taken in any cycle
  // where valid_i=1 and stall_o=0.

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_IO = 1'b1
  } state_t;

  localparam int CW = (IO_TIMEOUT < 2) ? 1 : $clog2(IO_TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     wait_q, wait_d;

  logic [3:0]        region;
  logic              is_dmem, is_bios, is_io, unmapped;
  logic              is_load, misaligned, wr_ok;
  logic [1:0]        offset;
  logic [DWIDTH-1:0] src, load_data, result;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  logic              stall_c;
  logic              we_d, mis_d, err_d;
  logic [DWIDTH-1:0] wd_d;

  wire unused_addr_bits = ^addr_i[27:2];

  assign region   = addr_i[31:28];
  assign is_dmem  = (region == DMEM_REGION) || (region == 4'b0011);
  assign is_bios  = (region == BIOS_REGION);
  assign is_io    = (region == IO_REGION);
  assign unmapped = ~(is_dmem | is_bios | is_io);
  assign is_load  = (wb_sel_i == 2'b01);
  assign offset   = addr_i[1:0];
  assign wr_ok    = valid_i & rd_we_i & (rd_i != '0) & ~flush_i;

  always_comb begin
    src = '0;
    if (is_dmem)      src = dmem_dout_i;
    else if (is_bios) src = bios_dout_i;
    else if (is_io)   src = io_dout_i;
  end

  always_comb begin
    byte_v    = src[8*offset +: 8];
    half_v    = src[16*offset[1] +: 16];
    load_data = src;
    case (funct3_i)
      3'b000:  load_data = {{(DWIDTH-8){byte_v[7]}}, byte_v};
      3'b100:  load_data = {{(DWIDTH-8){1'b0}}, byte_v};
      3'b001:  load_data = {{(DWIDTH-16){half_v[15]}}, half_v};
      3'b101:  load_data = {{(DWIDTH-16){1'b0}}, half_v};
      default: load_data = src;
    endcase
  end

  // Undefined funct3 codes behave as LW, so they need full word alignment too.
  always_comb begin
    case (funct3_i)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = offset[0];
      default:        misaligned = (offset != 2'b00);
    endcase
  end

  always_comb begin
    case (wb_sel_i)
      2'b00:   result = alu_result_i;
      2'b01:   result = unmapped ? '0 : load_data;
      2'b10:   result = pc_plus4_i;
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    stall_c = 1'b0;
    we_d    = 1'b0;
    wd_d    = '0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i && !flush_i) begin
          if (is_load && is_io && !misaligned && !io_valid_i) begin
            state_d = WAIT_IO;
            wait_d  = CW'(1);
            stall_c = 1'b1;
          end else begin
            wd_d = result;
            if (is_load && misaligned) mis_d = 1'b1;
            else                       we_d  = wr_ok;
            err_d = is_load & unmapped;
          end
        end
      end
      WAIT_IO: begin
        wait_d = wait_q + CW'(1);
        // io_valid_i is checked before the timeout so late data still wins.
        if (flush_i) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (io_valid_i) begin
          state_d = IDLE;
          wait_d  = '0;
          wd_d    = load_data;
          we_d    = wr_ok;
        end else if (wait_q == CW'(IO_TIMEOUT)) begin
          state_d = IDLE;
          wait_d  = '0;
          we_d    = wr_ok;
          err_d   = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
  end

  assign stall_o = stall_c & ~rst;
  assign state_o = (state_q == WAIT_IO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      rd_o       <= '0;
      rd_we_o    <= 1'b0;
      wd_o       <= '0;
      misalign_o <= 1'b0;
      err_o      <= 1'b0;
      wb_count_o <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rd_o       <= rd_i;
      rd_we_o    <= we_d;
      wd_o       <= wd_d;
      misalign_o <= mis_d;
      err_o      <= err_d;
      wb_count_o <= wb_count_o + {31'd0, we_d};
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: loads, region decode, IO wait/timeout,
// flush and reset behaviour, with hand-computed expected values.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush_i, rd_we_i, io_valid_i;
  logic [4:0]  rd_i;
  logic [1:0]  wb_sel_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, alu_result_i, pc_plus4_i, dmem_dout_i, bios_dout_i, io_dout_i;
  logic        stall_o, rd_we_o, misalign_o, err_o, state_o;
  logic [4:0]  rd_o;
  logic [31:0] wd_o, wb_count_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage #(.IO_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i),
    .rd_i(rd_i), .rd_we_i(rd_we_i), .wb_sel_i(wb_sel_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .alu_result_i(alu_result_i), .pc_plus4_i(pc_plus4_i),
    .dmem_dout_i(dmem_dout_i), .bios_dout_i(bios_dout_i), .io_dout_i(io_dout_i),
    .io_valid_i(io_valid_i), .stall_o(stall_o), .rd_o(rd_o), .rd_we_o(rd_we_o),
    .wd_o(wd_o), .misalign_o(misalign_o), .err_o(err_o), .wb_count_o(wb_count_o),
    .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_i = 0; flush_i = 0; rd_i = 0; rd_we_i = 0; wb_sel_i = 0; funct3_i = 0;
    addr_i = 0; alu_result_i = 0; pc_plus4_i = 0; io_valid_i = 0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] addr);
    valid_i = 1; flush_i = 0; rd_i = rd; rd_we_i = 1; wb_sel_i = sel; funct3_i = f3;
    addr_i = addr;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] wd);
    check({tag, " rd_we"}, {31'd0, rd_we_o}, 32'd1);
    check({tag, " rd"}, {27'd0, rd_o}, {27'd0, rd});
    check({tag, " wd"}, wd_o, wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; idle();
    dmem_dout_i = 0; bios_dout_i = 0; io_dout_i = 0;
    step(); step();
    check("reset rd_o", {27'd0, rd_o}, 32'd0);
    check("reset rd_we", {31'd0, rd_we_o}, 32'd0);
    check("reset wd", wd_o, 32'd0);
    check("reset misalign", {31'd0, misalign_o}, 32'd0);
    check("reset err", {31'd0, err_o}, 32'd0);
    check("reset count", wb_count_o, 32'd0);
    // IO entry condition presented during reset must not stall
    issue(5'd7, 2'b01, 3'b010, 32'h8000_0000);
    #1 check("stall in reset", {31'd0, stall_o}, 32'd0);
    step();
    rst = 0; idle();

    // DMEM sub-word loads
    dmem_dout_i = 32'h80FF_7F01;
    issue(5'd3, 2'b01, 3'b000, 32'h1000_0002);
    #1 check("lb stall", {31'd0, stall_o}, 32'd0);
    step(); check_write("lb", 5'd3, 32'hFFFF_FFFF);
    issue(5'd3, 2'b01, 3'b100, 32'h1000_0002);
    step(); check_write("lbu", 5'd3, 32'h0000_00FF);
    issue(5'd3, 2'b01, 3'b001, 32'h1000_0002);
    step(); check_write("lh", 5'd3, 32'hFFFF_80FF);
    issue(5'd4, 2'b01, 3'b101, 32'h1000_0000);
    step(); check_write("lhu", 5'd4, 32'h0000_7F01);
    issue(5'd4, 2'b01, 3'b000, 32'h1000_0000);
    step(); check_write("lb off0", 5'd4, 32'h0000_0001);
    issue(5'd4, 2'b01, 3'b000, 32'h3000_0001);
    step(); check_write("lb alias", 5'd4, 32'h0000_007F);

    // BIOS word loads, aligned then misaligned
    bios_dout_i = 32'hDEAD_BEEF;
    issue(5'd4, 2'b01, 3'b010, 32'h4000_0004);
    step(); check_write("bios lw", 5'd4, 32'hDEAD_BEEF);
    check("bios lw misalign", {31'd0, misalign_o}, 32'd0);
    issue(5'd4, 2'b01, 3'b010, 32'h4000_0006);
    step();
    check("misaligned rd_we", {31'd0, rd_we_o}, 32'd0);
    check("misaligned pulse", {31'd0, misalign_o}, 32'd1);
    idle(); step();
    check("misalign pulse end", {31'd0, misalign_o}, 32'd0);
    check("count after loads", wb_count_o, 32'd7);

    // PC+4 to x0 and to x5, ALU, reserved select, rd_we_i low
    issue(5'd0, 2'b10, 3'b000, 32'h0);
    pc_plus4_i = 32'h104;
    step(); check("jal x0 rd_we", {31'd0, rd_we_o}, 32'd0);
    idle(); step();
    check("count after x0", wb_count_o, 32'd7);
    issue(5'd5, 2'b10, 3'b000, 32'h0);
    pc_plus4_i = 32'h104;
    step(); check_write("jal x5", 5'd5, 32'h0000_0104);
    issue(5'd9, 2'b00, 3'b000, 32'h0);
    alu_result_i = 32'hCAFE_F00D;
    step(); check_write("alu", 5'd9, 32'hCAFE_F00D);
    issue(5'd10, 2'b11, 3'b000, 32'h0);
    alu_result_i = 32'h1111_2222;
    step(); check_write("reserved sel", 5'd10, 32'h0);
    issue(5'd11, 2'b00, 3'b000, 32'h0);
    rd_we_i = 0;
    step(); check("rd_we_i low", {31'd0, rd_we_o}, 32'd0);
    idle(); step();
    check("count after alu", wb_count_o, 32'd10);

    // Unmapped load: zero data, error pulse, write still happens
    issue(5'd6, 2'b01, 3'b010, 32'h2000_0000);
    step(); check_write("unmapped", 5'd6, 32'h0);
    check("unmapped err", {31'd0, err_o}, 32'd1);
    idle(); step();
    check("unmapped err end", {31'd0, err_o}, 32'd0);
    check("count after unmapped", wb_count_o, 32'd11);

    // IO load answered three cycles after issue
    issue(5'd7, 2'b01, 3'b010, 32'h8000_0000);
    #1 check("io wait stall c0", {31'd0, stall_o}, 32'd1);
    step(); check("io wait stall c1", {31'd0, stall_o}, 32'd1);
    check("io wait no write c1", {31'd0, rd_we_o}, 32'd0);
    check("io wait state", {31'd0, state_o}, 32'd1);
    step(); check("io wait stall c2", {31'd0, stall_o}, 32'd1);
    io_valid_i = 1; io_dout_i = 32'h1234_5678;
    #1 check("io wait stall c3", {31'd0, stall_o}, 32'd0);
    step(); check_write("io wait", 5'd7, 32'h1234_5678);
    check("io wait err", {31'd0, err_o}, 32'd0);

    // IO data already valid at issue: no stall
    issue(5'd7, 2'b01, 3'b100, 32'h8000_0003);
    io_valid_i = 1; io_dout_i = 32'hAB00_0000;
    #1 check("io immediate stall", {31'd0, stall_o}, 32'd0);
    step(); check_write("io immediate lbu", 5'd7, 32'h0000_00AB);
    idle(); step();
    check("count after io", wb_count_o, 32'd13);

    // Timeout with IO_TIMEOUT=4: four stall cycles, then zero write with error
    issue(5'd8, 2'b01, 3'b010, 32'h8000_0000);
    #1 check("timeout stall c0", {31'd0, stall_o}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      step();
      check($sformatf("timeout stall c%0d", i), {31'd0, stall_o}, 32'd1);
      check($sformatf("timeout no write c%0d", i), {31'd0, rd_we_o}, 32'd0);
    end
    step(); check("timeout stall c4", {31'd0, stall_o}, 32'd0);
    step(); check_write("timeout", 5'd8, 32'h0);
    check("timeout err", {31'd0, err_o}, 32'd1);
    idle(); step();
    check("timeout err end", {31'd0, err_o}, 32'd0);

    // io_valid_i arrives in the timeout cycle: data wins, no error
    issue(5'd9, 2'b01, 3'b010, 32'h8000_0000);
    step(); step(); step(); step();
    io_valid_i = 1; io_dout_i = 32'h0BAD_F00D;
    #1 check("late io stall", {31'd0, stall_o}, 32'd0);
    step(); check_write("late io", 5'd9, 32'h0BAD_F00D);
    check("late io err", {31'd0, err_o}, 32'd0);
    idle(); step();
    check("count after timeout", wb_count_o, 32'd15);

    // Flush during the wait
    issue(5'd12, 2'b01, 3'b010, 32'h8000_0000);
    step(); check("flush wait stall", {31'd0, stall_o}, 32'd1);
    flush_i = 1;
    #1 check("flush drops stall", {31'd0, stall_o}, 32'd0);
    step();
    check("flush no write", {31'd0, rd_we_o}, 32'd0);
    check("flush no err", {31'd0, err_o}, 32'd0);
    check("flush back to idle", {31'd0, state_o}, 32'd0);
    idle(); io_valid_i = 1; io_dout_i = 32'h5555_AAAA;
    step(); check("after flush no write", {31'd0, rd_we_o}, 32'd0);

    // Flush in IDLE: ALU write and unmapped load produce nothing
    issue(5'd3, 2'b00, 3'b000, 32'h0);
    alu_result_i = 32'h7777_7777; flush_i = 1;
    step(); check("flush alu rd_we", {31'd0, rd_we_o}, 32'd0);
    issue(5'd6, 2'b01, 3'b010, 32'h2000_0000);
    flush_i = 1;
    step(); check("flush unmapped err", {31'd0, err_o}, 32'd0);
    idle(); step();
    check("count after flush", wb_count_o, 32'd15);

    // Reset while waiting on IO
    issue(5'd13, 2'b01, 3'b010, 32'h8000_0000);
    step();
    rst = 1;
    #1 check("stall during reset", {31'd0, stall_o}, 32'd0);
    step();
    check("wait reset rd_we", {31'd0, rd_we_o}, 32'd0);
    check("wait reset wd", wd_o, 32'd0);
    check("wait reset rd", {27'd0, rd_o}, 32'd0);
    check("wait reset count", wb_count_o, 32'd0);
    check("wait reset state", {31'd0, state_o}, 32'd0);
    rst = 0; idle(); io_valid_i = 1; io_dout_i = 32'h9999_9999;
    #1 check("after reset stall", {31'd0, stall_o}, 32'd0);
    step(); check("stale io no write", {31'd0, rd_we_o}, 32'd0);
    issue(5'd2, 2'b00, 3'b000, 32'h0);
    alu_result_i = 32'h0000_0042;
    step(); check_write("alu after reset", 5'd2, 32'h0000_0042);
    idle(); step();
    check("count after reset", wb_count_o, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
